decoder_stage_controller_multi: RTL and testbench
=================================================

# decoder_stage_controller_multi

Parametrised stage controller for the union-find decoder, generalising the two-sided left/right controller pair to `NUM_PARTITIONS` partitions coordinated by one controller. It sequences measurement loading, grow, merge and result stages. A stage advances only after every partition acknowledges it, and merge completes only after all partitions report quiescence for a programmable settle window. It also counts iterations and cycles, and flags deadlock on iteration or cycle overrun.

## Interface
Parameters:
- `NUM_PARTITIONS`, 2: number of decoder partitions coordinated.
- `ITERATION_COUNTER_WIDTH`, 8: width of the iteration counter.
- `MAX_ITERATIONS`, 16: grow/merge iteration limit; must be ≤ 2^`ITERATION_COUNTER_WIDTH`−1.
- `SETTLE_CYCLES`, 4: consecutive quiet cycles required to close merge (link latency); ≥1.
- `WATCHDOG_CYCLES`, 4096: merge cycle limit, used only with the macro in Configuration.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `new_round_start`  in  1  single-cycle round start; honoured only in IDLE.
- `has_message_flying`  in  NUM_PARTITIONS  per-partition messages in flight.
- `has_odd_clusters`  in  NUM_PARTITIONS  per-partition odd cluster present.
- `stage_ack`  in  NUM_PARTITIONS  per-partition ack of the current stage (pulse or level).
- `result_ready`  in  1  consumer accepts the result.
- `stage`  out  STAGE_WIDTH  current stage.
- `stage_valid`  out  1  high while stage acks are outstanding.
- `result_valid`  out  1  result available.
- `iteration_counter`  out  ITERATION_COUNTER_WIDTH  completed grow/merge iterations.
- `cycle_counter`  out  32  cycles since round start.
- `deadlock`  out  1  round aborted on a limit.

## Operation
- Stages: IDLE(0), MEASUREMENT_LOADING(1), GROW(2), MERGE(3), RESULT_VALID(4).
- On every stage entry:
  - `ack_mask` clears and `stage_valid` goes high.
  - Each `stage_ack[i]` sets `ack_mask[i]`; bits are sticky.
  - When `ack_mask` reaches all-ones, `stage_valid` drops the next cycle.
  - The state never leaves a stage while `stage_valid` is high.
- IDLE → MEASUREMENT_LOADING on `new_round_start`.
  - Clears `iteration_counter`, `cycle_counter` and `deadlock`.
  - IDLE itself issues no ack request; `stage_valid` is 0 there.
- MEASUREMENT_LOADING → GROW once all acks are in.
- GROW → MERGE once all acks are in. Grow is one step.
- MERGE:
  - `quiet_cnt` increments each cycle `~|has_message_flying` holds, else resets to 0.
  - Close when `quiet_cnt == SETTLE_CYCLES` and all acks are in.
  - On close, `iteration_counter` += 1.
  - If `|has_odd_clusters` and the new count < `MAX_ITERATIONS` → GROW.
  - If `|has_odd_clusters` and the new count == `MAX_ITERATIONS` → RESULT_VALID with `deadlock`=1.
  - If no odd clusters → RESULT_VALID.
- RESULT_VALID:
  - `result_valid`=1 once acks are in.
  - Exits to IDLE on the cycle `result_valid && result_ready`.
  - `deadlock` holds until the next round start.
- `cycle_counter` increments in every non-IDLE stage, saturates at all-ones and freezes in RESULT_VALID.
- `new_round_start` outside IDLE is ignored.

## Timing
- Reset (async assert, sync deassert): `stage`=IDLE, all counters 0, `stage_valid`=0, `result_valid`=0, `deadlock`=0.
- Reset mid-round aborts immediately to IDLE.
- `stage`, `stage_valid`, `result_valid` and `deadlock` are all registered outputs.
- Minimum round with no odd clusters and all acks same-cycle: start → RESULT_VALID in 3 + `SETTLE_CYCLES` + 3 cycles.
- Simultaneous events:
  - An ack arriving in the stage-entry cycle is lost; partitions ack ≥1 cycle after a `stage` change.
  - A `has_message_flying` rise in the closing cycle blocks the close.
- The `quiet_cnt` comparator saturates; it has no wrap.

## Configuration
- `DECODER_STAGE_WATCHDOG_EN` defined:
  - A merge cycle counter resets on MERGE entry.
  - Reaching `WATCHDOG_CYCLES` forces RESULT_VALID with `deadlock`=1, even with acks outstanding.
- Undefined: no watchdog. Deadlock comes only from `MAX_ITERATIONS`, and MERGE may wait indefinitely.

## Structure
- Package `decoder_ctrl_pkg`: stage enum, `STAGE_WIDTH`=3, stage encodings. Shared with the partition-side logic.
- Sub-module `stage_ack_collector` (NUM_PARTITIONS): sticky `ack_mask`, clear-on-entry, all-ack flag, `stage_valid`.

## Test plan
- `NUM_PARTITIONS`=4, `SETTLE_CYCLES`=4, odd=0, acks one cycle after each change → RESULT_VALID, `iteration_counter`=1, `deadlock`=0.
- Partition 2 acks GROW 10 cycles late → state held in GROW for those cycles with `stage_valid`=1; other partitions unaffected.
- `has_message_flying[1]` pulses at quiet count 3 → `quiet_cnt` restarts; merge closes 4 quiet cycles later.
- `has_odd_clusters` held high, `MAX_ITERATIONS`=16 → RESULT_VALID with `iteration_counter`=16, `deadlock`=1.
- With macro, `WATCHDOG_CYCLES`=50, flying held high → `deadlock`=1 at merge cycle 50. Without macro → still in MERGE at cycle 1000.
- Reset low during MERGE, then `result_ready` held low → IDLE and zeros immediately; a new round holds `result_valid` until ready.

Source files
------------

// File: rtl/decoder_ctrl_pkg.sv
// Stage encodings shared by the multi-partition stage controller and the
// partition-side logic. Provides STAGE_WIDTH, the stage enum and helpers.
package decoder_ctrl_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        S_IDLE                = 3'd0,
        S_MEASUREMENT_LOADING = 3'd1,
        S_GROW                = 3'd2,
        S_MERGE               = 3'd3,
        S_RESULT_VALID        = 3'd4
    } stage_e;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = S_IDLE;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEAS_LOADING = S_MEASUREMENT_LOADING;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW         = S_GROW;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE        = S_MERGE;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID = S_RESULT_VALID;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/decoder_stage_controller_multi_if.sv
// Bundle between the stage controller and its partitions / result consumer.
// master: partitions + consumer side. slave: the controller.
interface decoder_stage_controller_multi_if
    import decoder_ctrl_pkg::*;
#(
    parameter int NUM_PARTITIONS          = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8
);

    logic                               new_round_start;
    logic [NUM_PARTITIONS-1:0]          has_message_flying;
    logic [NUM_PARTITIONS-1:0]          has_odd_clusters;
    logic [NUM_PARTITIONS-1:0]          stage_ack;
    logic                               result_ready;
    logic [STAGE_WIDTH-1:0]             stage;
    logic                               stage_valid;
    logic                               result_valid;
    logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
    logic [31:0]                        cycle_counter;
    logic                               deadlock;

    modport master (
        output new_round_start,
        output has_message_flying,
        output has_odd_clusters,
        output stage_ack,
        output result_ready,
        input  stage,
        input  stage_valid,
        input  result_valid,
        input  iteration_counter,
        input  cycle_counter,
        input  deadlock
    );

    modport slave (
        input  new_round_start,
        input  has_message_flying,
        input  has_odd_clusters,
        input  stage_ack,
        input  result_ready,
        output stage,
        output stage_valid,
        output result_valid,
        output iteration_counter,
        output cycle_counter,
        output deadlock
    );

endinterface

// File: rtl/stage_ack_collector.sv
// Collects per-partition stage acks into a sticky mask that clears on stage
// entry. Ports: clk, reset (async active-low), enter (stage changes at the
// next edge), arm (new stage requests acks), stage_ack in; all_acked
// (mask full including this cycle's acks), stage_valid (registered) out.
module stage_ack_collector #(
    parameter int NUM_PARTITIONS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic                      arm,
    input  logic [NUM_PARTITIONS-1:0] stage_ack,
    output logic                      all_acked,
    output logic                      stage_valid
);

    logic [NUM_PARTITIONS-1:0] ack_mask_q, ack_mask_d;
    logic                      entry_q, entry_d;
    logic                      stage_valid_q, stage_valid_d;

    // Acks seen in the entry cycle belong to the previous stage: drop them.
    always_comb begin
        ack_mask_d = ack_mask_q;
        if (!entry_q)
            ack_mask_d = ack_mask_q | stage_ack;
    end

    assign all_acked = &ack_mask_d;

    always_comb begin
        stage_valid_d = stage_valid_q & ~all_acked;
        entry_d       = 1'b0;
        if (enter) begin
            stage_valid_d = arm;
            entry_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_mask_q    <= '0;
            entry_q       <= 1'b0;
            stage_valid_q <= 1'b0;
        end else begin
            ack_mask_q    <= enter ? '0 : ack_mask_d;
            entry_q       <= entry_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    assign stage_valid = stage_valid_q;

endmodule

// File: rtl/decoder_stage_controller_multi.sv
// Union-find decoder stage controller for NUM_PARTITIONS partitions:
// IDLE -> MEAS_LOADING -> GROW <-> MERGE -> RESULT_VALID, with iteration
// and cycle counters and a deadlock flag on iteration overrun.
// Ports: clk, reset (async active-low), bus (slave modport, see _if).
// Optional merge watchdog: define DECODER_STAGE_WATCHDOG_EN.
module decoder_stage_controller_multi
    import decoder_ctrl_pkg::*;
#(
    parameter int NUM_PARTITIONS          = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAX_ITERATIONS          = 16,
    parameter int SETTLE_CYCLES           = 4,
    parameter int WATCHDOG_CYCLES         = 4096
) (
    input  logic clk,
    input  logic reset,
    decoder_stage_controller_multi_if.slave bus
);

    localparam int IW = ITERATION_COUNTER_WIDTH;
    localparam int QW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_MAX  = QW'(SETTLE_CYCLES);
    localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITERATIONS);

    if (SETTLE_CYCLES < 1 || WATCHDOG_CYCLES < 1 ||
        MAX_ITERATIONS > (2 ** ITERATION_COUNTER_WIDTH) - 1) begin : g_cfg_err
        $error("decoder_stage_controller_multi: bad parameters");
    end

    logic [STAGE_WIDTH-1:0] stage_q, stage_d;
    logic [IW-1:0]          iter_q, iter_d;
    logic [31:0]            cycle_q, cycle_d;
    logic [QW-1:0]          quiet_q, quiet_d;
    logic                   dead_q, dead_d;
    logic                   rv_q, rv_d;
    logic                   all_acked;
    logic                   stage_valid;
    logic                   enter;

`ifdef DECODER_STAGE_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(WATCHDOG_CYCLES);
    logic [31:0] wd_q, wd_d;
`endif

    always_comb begin
        stage_d = stage_q;
        iter_d  = iter_q;
        cycle_d = cycle_q;
        dead_d  = dead_q;
        rv_d    = 1'b0;
        quiet_d = '0;

        // Quiet run length saturates at the settle window.
        if (stage_q == STAGE_MERGE && ~|bus.has_message_flying)
            quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 1'b1;

        if (stage_q != STAGE_IDLE && stage_q != STAGE_RESULT_VALID)
            cycle_d = sat_inc32(cycle_q);

        unique case (stage_q)
            STAGE_IDLE: begin
                if (bus.new_round_start) begin
                    stage_d = STAGE_MEAS_LOADING;
                    iter_d  = '0;
                    cycle_d = '0;
                    dead_d  = 1'b0;
                end
            end
            STAGE_MEAS_LOADING: begin
                if (!stage_valid)
                    stage_d = STAGE_GROW;
            end
            STAGE_GROW: begin
                if (!stage_valid)
                    stage_d = STAGE_MERGE;
            end
            STAGE_MERGE: begin
                // quiet_d includes this cycle, so a flying rise now blocks.
                if (!stage_valid && quiet_d == QUIET_MAX) begin
                    iter_d = iter_q + 1'b1;
                    if (|bus.has_odd_clusters) begin
                        if (iter_d >= ITER_LIMIT) begin
                            stage_d = STAGE_RESULT_VALID;
                            dead_d  = 1'b1;
                        end else begin
                            stage_d = STAGE_GROW;
                        end
                    end else begin
                        stage_d = STAGE_RESULT_VALID;
                    end
                end
            end
            STAGE_RESULT_VALID: begin
                if (rv_q && bus.result_ready)
                    stage_d = STAGE_IDLE;
                else
                    rv_d = all_acked;
            end
            default: begin
                stage_d = STAGE_IDLE;
            end
        endcase

`ifdef DECODER_STAGE_WATCHDOG_EN
        // Runs from zero on every MERGE entry; overrides acks and settle.
        wd_d = (stage_q == STAGE_MERGE) ? wd_q + 32'd1 : '0;
        if (stage_q == STAGE_MERGE && wd_d >= WD_LIMIT) begin
            stage_d = STAGE_RESULT_VALID;
            dead_d  = 1'b1;
        end
`endif
    end

    assign enter = (stage_d != stage_q);

    stage_ack_collector #(
        .NUM_PARTITIONS(NUM_PARTITIONS)
    ) u_ack (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .arm        (stage_d != STAGE_IDLE),
        .stage_ack  (bus.stage_ack),
        .all_acked  (all_acked),
        .stage_valid(stage_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= STAGE_IDLE;
            iter_q  <= '0;
            cycle_q <= '0;
            quiet_q <= '0;
            dead_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            stage_q <= stage_d;
            iter_q  <= iter_d;
            cycle_q <= cycle_d;
            quiet_q <= quiet_d;
            dead_q  <= dead_d;
            rv_q    <= rv_d;
        end
    end

`ifdef DECODER_STAGE_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`endif

    assign bus.stage             = stage_q;
    assign bus.stage_valid       = stage_valid;
    assign bus.result_valid      = rv_q;
    assign bus.iteration_counter = iter_q;
    assign bus.cycle_counter     = cycle_q;
    assign bus.deadlock          = dead_q;

endmodule

// File: tb/tb_decoder_stage_controller_multi.sv
// Randomized bench for decoder_stage_controller_multi: partitions ack after
// random delays; stage durations and outcomes predicted per round.
module tb_decoder_stage_controller_multi;
    import decoder_ctrl_pkg::*;

    localparam int NP   = 4;
    localparam int IW   = 8;
    localparam int MAXI = 16;
    localparam int SC   = 4;
    localparam int WD   = 50;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    decoder_stage_controller_multi_if #(
        .NUM_PARTITIONS(NP),
        .ITERATION_COUNTER_WIDTH(IW)
    ) bus ();

    decoder_stage_controller_multi #(
        .NUM_PARTITIONS(NP),
        .ITERATION_COUNTER_WIDTH(IW),
        .MAX_ITERATIONS(MAXI),
        .SETTLE_CYCLES(SC),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.new_round_start    = 1'b0;
        bus.has_message_flying = '0;
        bus.has_odd_clusters   = '0;
        bus.stage_ack          = '0;
        bus.result_ready       = 1'b0;
    endtask

    function automatic logic [NP-1:0] onehot(input int k);
        logic [NP-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // One full round. Partitions ack d[i] cycles after each stage change;
    // MERGE sees a precomputed flying pattern; the model predicts how long
    // every stage lasts and where it goes next.
    task automatic run_round(input int n_odd, input bit fast, input int late_p,
                             input int late_d, input int hold, input bit pulse3,
                             input int rdy, input bit rst_mid);
        logic [STAGE_WIDTH-1:0] cur, nxt;
        logic [NP-1:0]          v;
        int  d [NP];
        bit  fly [0:1199];
        int  t, dmax, dur_exp, merges, iters, total, guard, fk, run, cls;
        bit  odd, dead_exp, done, closes, wd_hit;

        bus.new_round_start = 1'b1;
        @(posedge clk); #1;
        bus.new_round_start = 1'b0;
        check("start_stage", bus.stage, STAGE_MEAS_LOADING);
        check("start_cycles", bus.cycle_counter, 0);
        check("start_iters", bus.iteration_counter, 0);
        check("start_deadlock", bus.deadlock, 0);

        cur = bus.stage; t = 0; merges = 0; iters = 0; total = 0;
        guard = 0; done = 0; dead_exp = 0; odd = 0; fk = 0;
        nxt = STAGE_IDLE; dmax = 1; dur_exp = 3;

        while (!done) begin
            if (t == 0) begin
                dmax = 1;
                for (int i = 0; i < NP; i++) begin
                    d[i] = fast ? 1 : int'($urandom_range(1, 4));
                    if (cur == STAGE_GROW && i == late_p) d[i] = late_d;
                    if (d[i] > dmax) dmax = d[i];
                end
                dur_exp = dmax + 2;
                if (cur == STAGE_MEAS_LOADING) nxt = STAGE_GROW;
                else if (cur == STAGE_GROW) nxt = STAGE_MERGE;
                else if (cur == STAGE_RESULT_VALID) begin
                    nxt     = STAGE_IDLE;
                    dur_exp = dmax + 2 + rdy;
                end else if (cur == STAGE_MERGE) begin
                    merges++;
                    odd = (merges <= n_odd);
                    fk  = pulse3 ? 1 : int'($urandom_range(0, NP - 1));
                    for (int c = 0; c < 1200; c++)
                        fly[c] = (c < hold) || (pulse3 && c == 3) ||
                                 (!fast && !pulse3 && c < 60 &&
                                  $urandom_range(0, 5) == 0);
                    run = 0; cls = -1;
                    for (int c = 0; c < 1200; c++) begin
                        run = fly[c] ? 0 : run + 1;
                        if (cls < 0 && c >= dmax + 1 && run >= SC) cls = c;
                    end
                    dur_exp = cls + 1;
                    closes  = 1; wd_hit = 0;
`ifdef DECODER_STAGE_WATCHDOG_EN
                    if (dur_exp >= WD) begin
                        wd_hit  = 1;
                        closes  = (dur_exp == WD);
                        dur_exp = WD;
                    end
`endif
                    if (closes) iters++;
                    if (wd_hit) begin
                        nxt = STAGE_RESULT_VALID; dead_exp = 1;
                    end else if (odd && iters < MAXI) begin
                        nxt = STAGE_GROW;
                    end else begin
                        nxt = STAGE_RESULT_VALID;
                        if (odd) dead_exp = 1;
                    end
                end
            end

            check("stage_valid", bus.stage_valid, t <= dmax);
            if (cur == STAGE_RESULT_VALID)
                check("result_valid", bus.result_valid, t >= dmax + 1);
`ifndef DECODER_STAGE_WATCHDOG_EN
            if (cur == STAGE_MERGE && hold >= 1000 && t == 1000)
                check("merge_waits", bus.stage, STAGE_MERGE);
`endif

            if (rst_mid && cur == STAGE_MERGE && t == 2) begin
                #2 reset = 1'b0;
                #1;
                check("rst_stage", bus.stage, STAGE_IDLE);
                check("rst_sv", bus.stage_valid, 0);
                check("rst_rv", bus.result_valid, 0);
                check("rst_iters", bus.iteration_counter, 0);
                check("rst_cycles", bus.cycle_counter, 0);
                check("rst_deadlock", bus.deadlock, 0);
                idle_inputs();
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                check("rst_idle", bus.stage, STAGE_IDLE);
                return;
            end

            v = '0;
            for (int i = 0; i < NP; i++)
                v[i] = (t == d[i]) ||
                       (t == 0 && !fast && $urandom_range(0, 1) == 1);
            bus.stage_ack = v;
            if (cur == STAGE_MERGE) begin
                bus.has_message_flying = (t < 1200 && fly[t]) ? onehot(fk) : '0;
                bus.has_odd_clusters   = odd ? onehot(int'($urandom_range(0, NP - 1))) : '0;
            end else begin
                bus.has_message_flying = NP'($urandom);
                bus.has_odd_clusters   = NP'($urandom);
            end
            bus.result_ready = (cur == STAGE_RESULT_VALID) &&
                ((t >= dmax + 1 + rdy) ||
                 (t <= dmax && !fast && $urandom_range(0, 1) == 1));
            bus.new_round_start = !fast && $urandom_range(0, 3) == 0;

            @(posedge clk); #1;
            t++; guard++;

            if (bus.stage != cur || t == dur_exp) begin
                check("stage_time", t, dur_exp);
                check("next_stage", bus.stage, nxt);
                if (cur != STAGE_RESULT_VALID) total += t;
                if (bus.stage == STAGE_RESULT_VALID) begin
                    check("rv_cycles", bus.cycle_counter, total);
                    check("rv_iters", bus.iteration_counter, iters);
                    check("rv_deadlock", bus.deadlock, dead_exp);
                    if (fast && n_odd == 0 && hold == 0 && !pulse3 && late_p < 0)
                        check("min_latency", total, 3 + SC + 3);
                end
                if (bus.stage == STAGE_IDLE) begin
                    check("end_cycles", bus.cycle_counter, total);
                    check("end_deadlock", bus.deadlock, dead_exp);
                    check("end_rv", bus.result_valid, 0);
                    check("end_sv", bus.stage_valid, 0);
                    done = 1;
                end
                cur = bus.stage;
                t   = 0;
            end
            if (guard > 6000) begin
                check("round_budget", guard, 6000);
                done = 1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #1;
        check("reset_stage", bus.stage, STAGE_IDLE);
        check("reset_sv", bus.stage_valid, 0);
        check("reset_rv", bus.result_valid, 0);
        check("reset_iters", bus.iteration_counter, 0);
        check("reset_cycles", bus.cycle_counter, 0);
        check("reset_deadlock", bus.deadlock, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_hold", bus.stage, STAGE_IDLE);

        run_round(0, 1, -1, 0, 0, 0, 0, 0);
        run_round(0, 1, 2, 11, 0, 0, 0, 0);
        run_round(0, 1, -1, 0, 0, 1, 0, 0);
        run_round(20, 0, -1, 0, 0, 0, 2, 0);
        run_round(0, 0, -1, 0, 1000, 0, 1, 0);
        run_round(1, 0, -1, 0, 0, 0, 0, 1);
        run_round(0, 0, -1, 0, 0, 0, 20, 0);
        for (int k = 0; k < 8; k++)
            run_round(int'($urandom_range(0, 3)), 0, -1, 0, 0, 0,
                      int'($urandom_range(0, 5)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
